// File: rtl/chacha20_ks_xor_stage.sv
// Payload cipher stage: XORs 128-bit beats with lanes of 512-bit ChaCha20 keystream blocks,
// taps the ciphertext copy for Poly1305 and counts payload bytes for the LEN block.
module chacha20_ks_xor_stage #(
    parameter int unsigned LANES = 4,
    parameter int unsigned CNT_W = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic                   decrypt_i,
    input  logic                   in_valid_i,
    input  logic [127:0]           in_data_i,
    input  logic [15:0]            in_keep_i,
    input  logic                   in_last_i,
    output logic                   in_ready_o,
    output logic                   ks_req_o,
    input  logic                   ks_valid_i,
    input  logic [128*LANES-1:0]   ks_data_i,
    output logic                   out_valid_o,
    output logic [127:0]           out_data_o,
    output logic [15:0]            out_keep_o,
    output logic                   out_last_o,
    input  logic                   out_ready_i,
    output logic                   pld_valid_o,
    output logic [127:0]           pld_data_o,
    output logic [15:0]            pld_keep_o,
    input  logic                   pld_ready_i,
    output logic [CNT_W-1:0]       pld_bytes_o,
    output logic                   msg_done_o
);

    localparam int unsigned BEAT_W = 128;
    localparam int unsigned KEEP_W = BEAT_W / 8;
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RUN} state_e;

    state_e                   state_q, state_d;
    logic [LANE_W-1:0]        lane_q, lane_d;
    logic                     out_valid_q, out_valid_d;
    logic [CNT_W-1:0]         pld_bytes_q, pld_bytes_d;
    logic                     msg_done_q, msg_done_d;
    logic [128*LANES-1:0]     ks_buf_q;
    logic [BEAT_W-1:0]        out_data_q, pld_data_q;
    logic [KEEP_W-1:0]        out_keep_q;
    logic                     out_last_q;

    logic                     xfer, accept, ks_take;
    logic [BEAT_W-1:0]        mask, masked_in, cipher;

    function automatic logic [BEAT_W-1:0] byte_mask(input logic [KEEP_W-1:0] keep);
        byte_mask = '0;
        for (int unsigned j = 0; j < KEEP_W; j++) begin
            byte_mask[8*j +: 8] = {8{keep[j]}};
        end
    endfunction

    assign xfer    = out_valid_q && out_ready_i && pld_ready_i;
    assign accept  = in_valid_i && in_ready_o && !start_i;
    assign ks_take = (state_q == ST_WAIT) && ks_valid_i;

    assign mask      = byte_mask(in_keep_i);
    assign masked_in = in_data_i & mask;
    assign cipher    = (in_data_i ^ ks_buf_q[BEAT_W*lane_q +: BEAT_W]) & mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; a start pulse re-arms from any state and overrides everything else
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_REQ:  state_d = ST_WAIT;
            ST_WAIT: if (ks_valid_i) state_d = ST_RUN;
            ST_RUN: begin
                if (accept) begin
                    if (in_last_i) begin
                        state_d = ST_IDLE;
                    end else if (lane_q == LAST_LANE) begin
                        state_d = ST_REQ;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (start_i) state_d = ST_REQ;
    end

    always_comb begin
        ks_req_o   = 1'b0;
        in_ready_o = 1'b0;
        case (state_q)
            ST_REQ:  ks_req_o   = 1'b1;
            ST_RUN:  in_ready_o = !out_valid_q || xfer;
            default: ks_req_o   = 1'b0;
        endcase
    end

    // Lane pointer, output valid and byte counter
    always_comb begin
        lane_d      = lane_q;
        out_valid_d = out_valid_q;
        pld_bytes_d = pld_bytes_q;
        msg_done_d  = xfer && out_last_q;
        if (xfer) out_valid_d = 1'b0;
        if (ks_take) lane_d = '0;
        if (accept) begin
            out_valid_d = 1'b1;
            lane_d      = lane_q + LANE_W'(1);
            pld_bytes_d = pld_bytes_q + CNT_W'($countones(in_keep_i));
        end
        if (start_i) begin
            lane_d      = '0;
            out_valid_d = 1'b0;
            pld_bytes_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q      <= '0;
            out_valid_q <= 1'b0;
            pld_bytes_q <= '0;
            msg_done_q  <= 1'b0;
        end else begin
            lane_q      <= lane_d;
            out_valid_q <= out_valid_d;
            pld_bytes_q <= pld_bytes_d;
            msg_done_q  <= msg_done_d;
        end
    end

    // Keystream and beat payload storage need no reset; valids qualify them
    always_ff @(posedge clk) begin
        if (ks_take) ks_buf_q <= ks_data_i;
        if (accept) begin
            out_data_q <= cipher;
            pld_data_q <= decrypt_i ? masked_in : cipher;
            out_keep_q <= in_keep_i;
            out_last_q <= in_last_i;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_keep_o  = out_keep_q;
    assign out_last_o  = out_last_q;
    assign pld_valid_o = out_valid_q;
    assign pld_data_o  = pld_data_q;
    assign pld_keep_o  = out_keep_q;
    assign pld_bytes_o = pld_bytes_q;
    assign msg_done_o  = msg_done_q;

endmodule

// File: tb/tb_chacha20_ks_xor_stage.sv
// Bench for chacha20_ks_xor_stage: directed vector table, hand sequences for stalls/restart/reset,
// and randomized messages checked against a ChaCha20 keystream byte-stream model.
module tb_chacha20_ks_xor_stage;

    logic         clk = 1'b0;
    logic         rst, start, decrypt, in_valid, in_last, in_ready, ks_req, ks_valid;
    logic [127:0] in_data, out_data, pld_data;
    logic [15:0]  in_keep, out_keep, pld_keep;
    logic [511:0] ks_data;
    logic         out_valid, out_last, out_ready, pld_valid, pld_ready, msg_done;
    logic [63:0]  pld_bytes;

    int checks = 0;
    int failures = 0;

    chacha20_ks_xor_stage dut (
        .clk(clk), .rst(rst), .start_i(start), .decrypt_i(decrypt),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_keep_i(in_keep), .in_last_i(in_last),
        .in_ready_o(in_ready), .ks_req_o(ks_req), .ks_valid_i(ks_valid), .ks_data_i(ks_data),
        .out_valid_o(out_valid), .out_data_o(out_data), .out_keep_o(out_keep), .out_last_o(out_last),
        .out_ready_i(out_ready), .pld_valid_o(pld_valid), .pld_data_o(pld_data), .pld_keep_o(pld_keep),
        .pld_ready_i(pld_ready), .pld_bytes_o(pld_bytes), .msg_done_o(msg_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           restart;
        logic [127:0] data;
        logic [15:0]  keep;
        logic         last;
        logic [127:0] exp_out;
        logic [63:0]  exp_bytes;
    } vec_t;

    typedef struct {
        logic [127:0] out;
        logic [127:0] pld;
        logic [15:0]  keep;
        logic         last;
    } exp_t;

    // Keystream source state
    logic [511:0] ks_q [$];
    bit           ks_auto = 1'b0;
    bit           ks_chacha = 1'b0;
    int           ks_lat = 1;
    logic [31:0]  ks_ctr = 32'd1;
    int           inj_req = 0;
    int           req_cnt = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out", name);
    endtask

    function automatic logic [127:0] qr(input logic [31:0] a, b, c, d);
        a += b; d ^= a; d = {d[15:0], d[31:16]};
        c += d; b ^= c; b = {b[19:0], b[31:20]};
        a += b; d ^= a; d = {d[23:0], d[31:24]};
        c += d; b ^= c; b = {b[24:0], b[31:25]};
        return {a, b, c, d};
    endfunction

    // ChaCha20 block for key 00..1f, nonce 000000090000004a00000000; word w at bits [32w +: 32]
    function automatic logic [511:0] chacha_block(input logic [31:0] ctr);
        logic [31:0] s [16];
        logic [31:0] x [16];
        logic [511:0] r;
        int q [8][4] = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
                         '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};
        s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int k = 0; k < 8; k++) s[4+k] = 32'h03020100 + 32'h04040404 * 32'(k);
        s[12] = ctr; s[13] = 32'h09000000; s[14] = 32'h4a000000; s[15] = 32'h0;
        x = s;
        for (int rd = 0; rd < 10; rd++) begin
            for (int j = 0; j < 8; j++) begin
                {x[q[j][0]], x[q[j][1]], x[q[j][2]], x[q[j][3]]} =
                    qr(x[q[j][0]], x[q[j][1]], x[q[j][2]], x[q[j][3]]);
            end
        end
        for (int w = 0; w < 16; w++) r[32*w +: 32] = x[w] + s[w];
        return r;
    endfunction

    function automatic logic [127:0] bmask(input logic [15:0] k);
        logic [127:0] m = '0;
        for (int j = 0; j < 16; j++) if (k[j]) m[8*j +: 8] = 8'hFF;
        return m;
    endfunction

    function automatic logic [15:0] rand_keep();
        int n = $urandom_range(16);
        logic [16:0] t = (17'd1 << n) - 17'd1;
        return t[15:0];
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin : req_counter
        forever begin
            @(negedge clk);
            if (ks_req) req_cnt++;
        end
    end

    // Core stand-in: answers each request (or injected pulse) after ks_lat cycles
    initial begin : ks_responder
        int inj_done = 0;
        ks_valid = 1'b0;
        ks_data  = '0;
        forever begin
            @(negedge clk);
            if ((ks_req && ks_auto) || inj_req != inj_done) begin
                inj_done = inj_req;
                repeat (ks_lat) @(posedge clk);
                #1;
                if (ks_chacha) begin
                    ks_data = chacha_block(ks_ctr);
                    ks_ctr  = ks_ctr + 32'd1;
                end else if (ks_q.size() > 0) begin
                    ks_data = ks_q.pop_front();
                end else begin
                    ks_data = {rand128(), rand128(), rand128(), rand128()};
                end
                ks_valid = 1'b1;
                @(posedge clk);
                #1;
                ks_valid = 1'b0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) note_fail(name);
        cyc();
    endtask

    task automatic send_beat(input string name, input logic [127:0] d, input logic [15:0] k,
                             input logic l, input logic [127:0] exp_out);
        in_valid = 1'b1; in_data = d; in_keep = k; in_last = l;
        @(negedge clk);
        check({name, " in_ready"}, in_ready, 1'b1);
        cyc();
        in_valid = 1'b0; in_last = 1'b0;
        check({name, " out_valid"}, out_valid, 1'b1);
        check({name, " out_data"}, out_data, exp_out);
    endtask

    // One message with random gaps and backpressure; expected beat k = in ^ keystream bytes [16k, 16k+16)
    task automatic run_msg(input int n, input bit dec, input bit zero_last);
        exp_t        eq [$];
        exp_t        e;
        logic [31:0] base;
        logic [63:0] bytes = '0;
        int          sent = 0, got = 0, budget = 0;
        bit          done_exp = 1'b0;
        decrypt = dec;
        do_start();
        base = ks_ctr;
        while (got < n && budget < 3000) begin
            if (!in_valid && sent < n && $urandom_range(3) != 0) begin
                in_valid = 1'b1;
                in_data  = rand128();
                in_last  = (sent == n - 1);
                in_keep  = (in_last && zero_last) ? 16'h0 : rand_keep();
            end
            out_ready = ($urandom_range(3) != 0);
            pld_ready = ($urandom_range(3) != 0);
            @(negedge clk);
            check("rand msg_done", msg_done, done_exp);
            done_exp = 1'b0;
            if (out_valid && out_ready && pld_ready) begin
                if (eq.size() == 0) begin
                    check("rand spurious out_valid", out_valid, 1'b0);
                end else begin
                    e = eq.pop_front();
                    check("rand out_data", out_data, e.out);
                    check("rand pld_data", pld_data, e.pld);
                    check("rand out_keep", out_keep, e.keep);
                    check("rand pld_keep", pld_keep, e.keep);
                    check("rand out_last", out_last, e.last);
                    check("rand pld_valid", pld_valid, 1'b1);
                    done_exp = e.last;
                    got++;
                end
            end
            if (in_valid && in_ready) begin
                logic [511:0] blk = chacha_block(base + 32'(sent / 4));
                logic [127:0] ln  = blk[128*(sent % 4) +: 128];
                e.out  = (in_data ^ ln) & bmask(in_keep);
                e.pld  = dec ? (in_data & bmask(in_keep)) : e.out;
                e.keep = in_keep;
                e.last = in_last;
                eq.push_back(e);
                bytes += 64'($countones(in_keep));
                sent++;
                cyc();
                in_valid = 1'b0;
                in_last  = 1'b0;
            end else begin
                cyc();
            end
            budget++;
        end
        if (got < n) note_fail("rand message drain");
        @(negedge clk);
        check("rand final msg_done", msg_done, done_exp);
        check("rand pld_bytes", pld_bytes, bytes);
        cyc();
        out_ready = 1'b1;
        pld_ready = 1'b1;
        decrypt   = 1'b0;
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        vec_t         vecs [5];
        logic [511:0] lanes_blk, blk;
        logic [127:0] d [4];
        int           req_base;

        rst = 1'b1; start = 1'b0; decrypt = 1'b0; in_valid = 1'b0; in_data = '0;
        in_keep = '0; in_last = 1'b0; out_ready = 1'b1; pld_ready = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        @(negedge clk);
        check("reset out_valid", out_valid, 1'b0);
        check("reset pld_valid", pld_valid, 1'b0);
        check("reset ks_req", ks_req, 1'b0);
        check("reset in_ready", in_ready, 1'b0);
        check("reset pld_bytes", pld_bytes, 64'd0);
        check("reset msg_done", msg_done, 1'b0);
        cyc();

        // Directed table: four full beats, then a restarted one-beat partial message
        lanes_blk = {{16{8'h08}}, {16{8'h04}}, {16{8'h02}}, {16{8'h01}}};
        repeat (3) ks_q.push_back(lanes_blk);
        ks_auto = 1'b1; ks_lat = 2;
        vecs[0] = '{1'b1, {16{8'hFF}}, 16'hFFFF, 1'b0, {16{8'hFE}}, 64'd16};
        vecs[1] = '{1'b0, {16{8'hFF}}, 16'hFFFF, 1'b0, {16{8'hFD}}, 64'd32};
        vecs[2] = '{1'b0, {16{8'hFF}}, 16'hFFFF, 1'b0, {16{8'hFB}}, 64'd48};
        vecs[3] = '{1'b0, {16{8'hFF}}, 16'hFFFF, 1'b0, {16{8'hF7}}, 64'd64};
        vecs[4] = '{1'b1, {16{8'hFF}}, 16'h001F, 1'b1, {88'h0, 40'hFEFEFEFEFE}, 64'd5};
        req_base = req_cnt;
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].restart) begin
                if (i > 0) begin
                    repeat (6) cyc();
                    check("vec ks_req count", 128'(req_cnt - req_base), 128'd2);
                end
                do_start();
                wait_ready($sformatf("vec%0d wait", i));
            end
            send_beat($sformatf("vec%0d", i), vecs[i].data, vecs[i].keep, vecs[i].last, vecs[i].exp_out);
            check($sformatf("vec%0d pld_bytes", i), pld_bytes, vecs[i].exp_bytes);
        end
        cyc();
        check("partial out_valid drained", out_valid, 1'b0);
        check("partial msg_done", msg_done, 1'b1);
        req_base = req_cnt;
        cyc();
        check("partial msg_done pulse", msg_done, 1'b0);
        repeat (3) cyc();
        check("partial idle in_ready", in_ready, 1'b0);
        check("partial idle no ks_req", 128'(req_cnt - req_base), 128'd0);
        check("partial pld_bytes", pld_bytes, 64'd5);

        // Decrypt: pld carries the input, out carries input ^ keystream
        ks_lat = 1;
        ks_q.push_back({rand128(), rand128(), rand128(), {16{8'hA5}}});
        decrypt = 1'b1;
        d[0] = 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_ABCD;
        do_start();
        wait_ready("dec wait");
        send_beat("dec", d[0], 16'hFFFF, 1'b1, d[0] ^ {16{8'hA5}});
        check("dec pld_data", pld_data, d[0]);
        decrypt = 1'b0;
        cyc();

        // Backpressure from either ready input alone
        blk = {rand128(), rand128(), rand128(), rand128()};
        ks_q.push_back(blk);
        for (int k = 0; k < 4; k++) d[k] = rand128();
        do_start();
        wait_ready("bp wait");
        pld_ready = 1'b0;
        send_beat("bp beat0", d[0], 16'hFFFF, 1'b0, d[0] ^ blk[127:0]);
        in_valid = 1'b1; in_data = d[1];
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp pld stall out_valid", out_valid, 1'b1);
            check("bp pld stall out_data", out_data, d[0] ^ blk[127:0]);
            check("bp pld stall in_ready", in_ready, 1'b0);
            cyc();
        end
        pld_ready = 1'b1;
        send_beat("bp beat1", d[1], 16'hFFFF, 1'b0, d[1] ^ blk[255:128]);
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = d[2];
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp out stall out_valid", out_valid, 1'b1);
            check("bp out stall out_data", out_data, d[1] ^ blk[255:128]);
            check("bp out stall in_ready", in_ready, 1'b0);
            cyc();
        end
        out_ready = 1'b1;
        send_beat("bp beat2", d[2], 16'hFFFF, 1'b0, d[2] ^ blk[383:256]);
        send_beat("bp beat3", d[3], 16'hFFFF, 1'b1, d[3] ^ blk[511:384]);
        cyc();
        check("bp drained", out_valid, 1'b0);
        check("bp pld_bytes", pld_bytes, 64'd64);

        // Restart mid-message drops the pending beat and rewinds to lane 0 of a fresh block
        blk = {rand128(), rand128(), rand128(), rand128()};
        lanes_blk = {rand128(), rand128(), rand128(), rand128()};
        ks_q.push_back(blk);
        ks_q.push_back(lanes_blk);
        d[0] = rand128(); d[1] = rand128();
        do_start();
        wait_ready("restart wait");
        send_beat("restart beat0", d[0], 16'hFFFF, 1'b0, d[0] ^ blk[127:0]);
        send_beat("restart beat1", d[1], 16'hFFFF, 1'b0, d[1] ^ blk[255:128]);
        out_ready = 1'b0;
        do_start();
        check("restart out_valid dropped", out_valid, 1'b0);
        check("restart pld_bytes", pld_bytes, 64'd0);
        @(negedge clk);
        check("restart ks_req", ks_req, 1'b1);
        cyc();
        out_ready = 1'b1;
        wait_ready("restart rewait");
        ks_auto = 1'b0;
        for (int k = 0; k < 4; k++) d[k] = rand128();
        send_beat("restart lane0", d[0], 16'hFFFF, 1'b0, d[0] ^ lanes_blk[127:0]);
        send_beat("restart lane1", d[1], 16'hFFFF, 1'b0, d[1] ^ lanes_blk[255:128]);
        send_beat("restart lane2", d[2], 16'hFFFF, 1'b0, d[2] ^ lanes_blk[383:256]);
        send_beat("restart lane3", d[3], 16'hFFFF, 1'b0, d[3] ^ lanes_blk[511:384]);
        out_ready = 1'b0;
        repeat (2) cyc();
        check("wait pld_bytes", pld_bytes, 64'd64);
        check("wait out_valid held", out_valid, 1'b1);

        // Reset while waiting for keystream, then a stray ks_valid must be ignored
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        out_ready = 1'b1;
        check("rst out_valid", out_valid, 1'b0);
        check("rst pld_bytes", pld_bytes, 64'd0);
        check("rst msg_done", msg_done, 1'b0);
        inj_req++;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rst idle in_ready", in_ready, 1'b0);
            check("rst idle ks_req", ks_req, 1'b0);
            cyc();
        end

        // Real ChaCha20 blocks from counter 1: ten beats span blocks 1..3
        ks_chacha = 1'b1;
        ks_auto = 1'b1;
        run_msg(10, 1'b0, 1'b0);
        run_msg(3, 1'b1, 1'b1);
        for (int m = 0; m < 12; m++) begin
            ks_lat = $urandom_range(1, 4);
            run_msg($urandom_range(1, 9), 1'($urandom_range(1)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
